// File: rtl/floppy_sector_stream_pkg.sv
// ---------------------------------------------------------------------------
// floppy_pkg
// Shared definitions for the floppy sector streamer:
//   - state_t       : stream FSM states
//   - KIND_*        : out_kind codes for the stream bytes
//   - AM_*          : address-mark bytes that seed the field CRCs
//   - CRC_POLY/INIT : CRC-16-CCITT constants
//   - ID_LEN        : number of bytes in the ID field including its CRC
//   - crc16_byte    : one byte of MSB-first CCITT update
//   - crc16_mark_preset : CRC value after the address mark of a field
// ---------------------------------------------------------------------------
package floppy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DCRC = 2'd3
  } state_t;

  localparam logic [1:0] KIND_ID    = 2'd0;
  localparam logic [1:0] KIND_IDCRC = 2'd1;
  localparam logic [1:0] KIND_DATA  = 2'd2;
  localparam logic [1:0] KIND_DCRC  = 2'd3;

  localparam logic [7:0] AM_SYNC = 8'hA1;
  localparam logic [7:0] AM_ID   = 8'hFE;
  localparam logic [7:0] AM_DATA = 8'hFB;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int ID_LEN = 6;

  // Byte-wide MSB-first CCITT step: fold the byte into the top and shift 8x.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // MFM fields are preceded by three A1 sync marks before the FE/FB mark;
  // SD fields only carry the FE/FB mark.
  function automatic logic [15:0] crc16_mark_preset(input logic       mfm,
                                                    input logic [7:0] mark);
    logic [15:0] c;
    c = CRC_INIT;
    if (mfm) begin
      for (int i = 0; i < 3; i++) begin
        c = crc16_byte(c, AM_SYNC);
      end
    end
    c = crc16_byte(c, mark);
    return c;
  endfunction

endpackage

// File: rtl/floppy_sector_stream_crc16.sv
// ---------------------------------------------------------------------------
// floppy_crc16
// Byte-wide CRC-16-CCITT accumulator.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, register returns to 0xFFFF
//   init     in   load init_val (wins over en)
//   init_val in   16-bit value loaded on init
//   en       in   fold data into the CRC this clk
//   data     in   8-bit data byte
//   crc      out  current CRC register
// ---------------------------------------------------------------------------
module floppy_crc16
  import floppy_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic [15:0] init_val,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC_INIT;
    end else if (init) begin
      r_crc <= init_val;
    end else if (en) begin
      r_crc <= crc16_byte(r_crc, data);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/floppy_sector_stream.sv
// ---------------------------------------------------------------------------
// floppy_sector_stream
// Turns the drive's sector_hdr/sector_data windows into the ordered FDC read
// stream: ID field (track, side, sector, size code, CRC), sector data from
// the sector buffer, then the data CRC. Also requests the buffer fetch for
// the sector now under the head.
//
// Build option: define FLOPPY_STREAM_CRC_EN to include the CRC generator;
// without it the CRC bytes are emitted as 0x00 with the same timing.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   dclk_en            drive byte tick (one clk wide)
//   sector_hdr/_data   drive header / data windows
//   track, sector, side, size_code, sector_len, density   sector geometry
//   req, req_track, req_sector   buffer fetch request
//   buf_ready, buf_rd, buf_addr, buf_din   sector buffer read port
//   out_valid, out_data, out_kind, out_last   stream byte output
//   miss               buffer was not ready at the first data byte
//
// Drive byte ticks are assumed to be at least two clks apart: a data byte
// reaches the CRC one clk after its tick.
// ---------------------------------------------------------------------------
module floppy_sector_stream
  import floppy_pkg::*;
#(
  parameter int SECT_AW = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dclk_en,
  input  logic               sector_hdr,
  input  logic               sector_data,
  input  logic [7:0]         track,
  input  logic [4:0]         sector,
  input  logic               side,
  input  logic [1:0]         size_code,
  input  logic [10:0]        sector_len,
  input  logic [1:0]         density,
  output logic               req,
  output logic [7:0]         req_track,
  output logic [4:0]         req_sector,
  input  logic               buf_ready,
  output logic               buf_rd,
  output logic [SECT_AW-1:0] buf_addr,
  input  logic [7:0]         buf_din,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic [1:0]         out_kind,
  output logic               out_last,
  output logic               miss
);

  state_t      r_state, w_stNext;
  logic [10:0] r_idx, w_idxNext;
  logic        r_hdrPrev;
  logic        r_miss, r_req;
  logic [7:0]  r_reqTrack;
  logic [4:0]  r_reqSector;
  logic        r_outValid, r_outLast, r_outFromBuf;
  logic [1:0]  r_outKind;
  logic [7:0]  r_outByte;

  logic        w_hdrRise, w_lastData;
  logic        w_emit, w_fromBuf, w_last, w_bufRd;
  logic        w_startHdr, w_setMiss, w_crcInit;
  logic [1:0]  w_kind;
  logic [7:0]  w_byte, w_crcMark;
  logic [15:0] w_crc;

  assign w_hdrRise  = sector_hdr && !r_hdrPrev;
  assign w_lastData = (r_idx == (sector_len - 11'd1));

  // State, byte index and header-edge history advance only on drive ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 11'd0;
      r_hdrPrev <= 1'b0;
    end else if (dclk_en) begin
      r_state   <= w_stNext;
      r_idx     <= w_idxNext;
      r_hdrPrev <= sector_hdr;
    end
  end

  // Next state and the byte consumed on this tick. Nothing here is active
  // without dclk_en, which keeps the FSM frozen while the motor is off.
  always_comb begin
    w_stNext   = r_state;
    w_idxNext  = r_idx;
    w_emit     = 1'b0;
    w_kind     = KIND_ID;
    w_byte     = 8'h00;
    w_fromBuf  = 1'b0;
    w_last     = 1'b0;
    w_bufRd    = 1'b0;
    w_startHdr = 1'b0;
    w_setMiss  = 1'b0;
    w_crcInit  = 1'b0;
    w_crcMark  = AM_ID;
    if (dclk_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (sector_hdr) begin
            w_startHdr = 1'b1;
          end
        end
        ST_HDR: begin
          w_emit = 1'b1;
          w_kind = (r_idx >= 11'(ID_LEN - 2)) ? KIND_IDCRC : KIND_ID;
          case (r_idx[2:0])
            3'd0:    w_byte = track;
            3'd1:    w_byte = {7'd0, side};
            3'd2:    w_byte = {3'd0, sector};
            3'd3:    w_byte = {6'd0, size_code};
            3'd4:    w_byte = w_crc[15:8];
            default: w_byte = w_crc[7:0];
          endcase
          if (r_idx == 11'(ID_LEN - 1)) begin
            // The lo CRC byte is already captured, so the data-field
            // preset can be loaded on this same tick.
            w_last    = 1'b1;
            w_stNext  = ST_DATA;
            w_idxNext = 11'd0;
            w_crcInit = 1'b1;
            w_crcMark = AM_DATA;
          end else begin
            w_idxNext = r_idx + 11'd1;
          end
        end
        ST_DATA: begin
          if (w_hdrRise) begin
            w_startHdr = 1'b1;
          end else if (sector_data) begin
            w_emit = 1'b1;
            w_kind = KIND_DATA;
            // Readiness is judged once, at the first byte; a miss zero-fills
            // the rest of the sector.
            if (r_idx == 11'd0) begin
              w_bufRd   = buf_ready;
              w_fromBuf = buf_ready;
              w_setMiss = !buf_ready;
            end else begin
              w_bufRd   = !r_miss;
              w_fromBuf = !r_miss;
            end
            if (w_lastData) begin
              w_last    = 1'b1;
              w_stNext  = ST_DCRC;
              w_idxNext = 11'd0;
            end else begin
              w_idxNext = r_idx + 11'd1;
            end
          end else if (r_idx != 11'd0) begin
            // Data window closed early: drop the field without CRC bytes.
            w_stNext  = ST_IDLE;
            w_idxNext = 11'd0;
          end
        end
        ST_DCRC: begin
          if (w_hdrRise) begin
            w_startHdr = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_kind = KIND_DCRC;
            if (r_idx == 11'd0) begin
              w_byte    = w_crc[15:8];
              w_idxNext = 11'd1;
            end else begin
              w_byte    = w_crc[7:0];
              w_last    = 1'b1;
              w_stNext  = ST_IDLE;
              w_idxNext = 11'd0;
            end
          end
        end
        default: begin
          w_stNext  = ST_IDLE;
          w_idxNext = 11'd0;
        end
      endcase
      if (w_startHdr) begin
        w_stNext  = ST_HDR;
        w_idxNext = 11'd0;
        w_crcInit = 1'b1;
        w_crcMark = AM_ID;
      end
    end
  end

  // Registered stream outputs, request and miss flag: all land one clk
  // after the tick that produced them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid   <= 1'b0;
      r_outLast    <= 1'b0;
      r_outFromBuf <= 1'b0;
      r_outKind    <= KIND_ID;
      r_outByte    <= 8'h00;
      r_req        <= 1'b0;
      r_reqTrack   <= 8'h00;
      r_reqSector  <= 5'd0;
      r_miss       <= 1'b0;
    end else begin
      r_outValid   <= w_emit;
      r_outLast    <= w_emit && w_last;
      r_outFromBuf <= w_emit && w_fromBuf;
      r_req        <= w_startHdr;
      if (w_emit) begin
        r_outByte <= w_byte;
        r_outKind <= w_kind;
      end
      if (w_startHdr) begin
        r_reqTrack  <= track;
        r_reqSector <= sector;
        r_miss      <= 1'b0;
      end else if (w_setMiss) begin
        r_miss <= 1'b1;
      end
    end
  end

`ifdef FLOPPY_STREAM_CRC_EN
  logic        w_crcEn;
  logic [15:0] w_crcPreset;

  // The CRC follows the emitted stream itself, so buffer bytes are folded
  // in during the clk they appear on buf_din.
  assign w_crcEn     = r_outValid && ((r_outKind == KIND_ID) || (r_outKind == KIND_DATA));
  assign w_crcPreset = crc16_mark_preset(density != 2'd0, w_crcMark);

  floppy_crc16 u_crc (
    .clk      (clk),
    .reset_n  (reset_n),
    .init     (w_crcInit),
    .init_val (w_crcPreset),
    .en       (w_crcEn),
    .data     (out_data),
    .crc      (w_crc)
  );
`else
  logic w_unusedCrcInputs;
  assign w_unusedCrcInputs = ^{density, w_crcInit, w_crcMark};
  assign w_crc             = 16'h0000;
`endif

  assign req        = r_req;
  assign req_track  = r_reqTrack;
  assign req_sector = r_reqSector;
  assign buf_rd     = w_bufRd;
  assign buf_addr   = SECT_AW'(r_idx);
  assign out_valid  = r_outValid;
  assign out_data   = r_outFromBuf ? buf_din : r_outByte;
  assign out_kind   = r_outKind;
  assign out_last   = r_outLast;
  assign miss       = r_miss;

endmodule

// File: tb/tb_floppy_sector_stream.sv
// ---------------------------------------------------------------------------
// tb_floppy_sector_stream
// Directed bench for floppy_sector_stream: a table of sector geometries with
// hand-computed ID bytes is streamed end to end, followed by hand-written
// sequences for buffer miss, header resync, data abort and reset mid-field.
// ---------------------------------------------------------------------------
module tb_floppy_sector_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dclk_en;
  logic        sector_hdr;
  logic        sector_data;
  logic [7:0]  track;
  logic [4:0]  sector;
  logic        side;
  logic [1:0]  size_code;
  logic [10:0] sector_len;
  logic [1:0]  density;
  logic        req;
  logic [7:0]  req_track;
  logic [4:0]  req_sector;
  logic        buf_ready;
  logic        buf_rd;
  logic [10:0] buf_addr;
  logic [7:0]  buf_din;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        miss;

  int nAssert = 0;
  int nFail   = 0;

  logic [7:0]  tbSeed;
  logic        sBufRd, sValid, sLast, sReq, sMiss, sValidAfter, sReqAfter;
  logic [10:0] sBufAddr;
  logic [7:0]  sData;
  logic [1:0]  sKind;

  typedef struct {
    logic [7:0]  trk;
    logic        sd;
    logic [4:0]  sec;
    logic [1:0]  size;
    logic [10:0] len;
    logic [1:0]  dens;
    logic [7:0]  seed;
    int          stall;
    logic [7:0]  id0, id1, id2, id3;
  } vec_t;

  vec_t vecs[4];

  floppy_sector_stream #(.SECT_AW(11)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dclk_en     (dclk_en),
    .sector_hdr  (sector_hdr),
    .sector_data (sector_data),
    .track       (track),
    .sector      (sector),
    .side        (side),
    .size_code   (size_code),
    .sector_len  (sector_len),
    .density     (density),
    .req         (req),
    .req_track   (req_track),
    .req_sector  (req_sector),
    .buf_ready   (buf_ready),
    .buf_rd      (buf_rd),
    .buf_addr    (buf_addr),
    .buf_din     (buf_din),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_kind    (out_kind),
    .out_last    (out_last),
    .miss        (miss)
  );

  always #5 clk = ~clk;

  // Sector buffer model: data one clk after the read strobe, junk otherwise.
  always @(posedge clk) begin
    buf_din <= buf_rd ? (buf_addr[7:0] ^ tbSeed) : 8'hEE;
  end

  // Bit-serial CCITT reference.
  function automatic logic [15:0] tbCrc(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] tbPreset(input logic mfm, input logic [7:0] mark);
    logic [15:0] r;
    r = 16'hFFFF;
    if (mfm) begin
      r = tbCrc(r, 8'hA1);
      r = tbCrc(r, 8'hA1);
      r = tbCrc(r, 8'hA1);
    end
    return tbCrc(r, mark);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One drive byte tick: combinational buffer strobe is sampled inside the
  // tick clk, registered outputs one clk later, and the pulse end one more.
  task automatic applyStimulus(input logic hdr, input logic dat);
    @(posedge clk); #1;
    sector_hdr  = hdr;
    sector_data = dat;
    dclk_en     = 1'b1;
    #2;
    sBufRd   = buf_rd;
    sBufAddr = buf_addr;
    @(posedge clk); #1;
    dclk_en  = 1'b0;
    sValid   = out_valid;
    sData    = out_data;
    sKind    = out_kind;
    sLast    = out_last;
    sReq     = req;
    sMiss    = miss;
    @(posedge clk); #1;
    sValidAfter = out_valid;
    sReqAfter   = req;
  endtask

  task automatic expectByte(input string name, input logic [7:0] d, input logic [1:0] k, input logic l);
    checkOutput({name, "_valid"}, 32'(sValid), 32'd1);
    checkOutput({name, "_data"},  32'(sData),  32'(d));
    checkOutput({name, "_kind"},  32'(sKind),  32'(k));
    checkOutput({name, "_last"},  32'(sLast),  32'(l));
    checkOutput({name, "_pulse"}, 32'(sValidAfter), 32'd0);
  endtask

  task automatic doStart(input logic [7:0] trk, input logic [4:0] sec, input logic sd,
                         input logic [1:0] size, input logic [10:0] len, input logic [1:0] dens);
    track = trk; sector = sec; side = sd; size_code = size; sector_len = len; density = dens;
    applyStimulus(1'b1, 1'b0);
    checkOutput("start_quiet", 32'(sValid), 32'd0);
    checkOutput("req",         32'(sReq), 32'd1);
    checkOutput("req_pulse",   32'(sReqAfter), 32'd0);
    checkOutput("req_track",   32'(req_track), 32'(trk));
    checkOutput("req_sector",  32'(req_sector), 32'(sec));
    checkOutput("miss_clear",  32'(sMiss), 32'd0);
  endtask

  task automatic doHeader(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic mfm);
    logic [7:0]  ids[4];
    logic [15:0] crc, rcv, expCrc;
    ids[0] = e0; ids[1] = e1; ids[2] = e2; ids[3] = e3;
    crc = tbPreset(mfm, 8'hFE);
    rcv = crc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      expectByte($sformatf("id%0d", i), ids[i], 2'd0, 1'b0);
      crc = tbCrc(crc, ids[i]);
      rcv = tbCrc(rcv, sData);
    end
`ifdef FLOPPY_STREAM_CRC_EN
    expCrc = crc;
`else
    expCrc = 16'h0000;
`endif
    applyStimulus(1'b0, 1'b0);
    expectByte("id_crc_hi", expCrc[15:8], 2'd1, 1'b0);
    rcv = tbCrc(rcv, sData);
    applyStimulus(1'b0, 1'b0);
    expectByte("id_crc_lo", expCrc[7:0], 2'd1, 1'b1);
    rcv = tbCrc(rcv, sData);
`ifdef FLOPPY_STREAM_CRC_EN
    checkOutput("id_residue", 32'(rcv), 32'd0);
`endif
  endtask

  task automatic doData(input int len, input logic [7:0] seed, input logic mfm,
                        input int nBytes, input int stall);
    logic [15:0] crc, rcv, expCrc;
    logic [7:0]  exp;
    logic        saw;
    tbSeed = seed;
    crc = tbPreset(mfm, 8'hFB);
    rcv = crc;
    for (int i = 0; i < nBytes; i++) begin
      if (i == stall) begin
        saw = 1'b0;
        repeat (1000) begin
          @(posedge clk); #1;
          saw = saw | out_valid | buf_rd;
        end
        checkOutput("stall_quiet", 32'(saw), 32'd0);
      end
      applyStimulus(1'b0, 1'b1);
      exp = buf_ready ? (8'(i) ^ seed) : 8'h00;
      checkOutput("data_rd", 32'(sBufRd), 32'(buf_ready));
      if (buf_ready) checkOutput("data_addr", 32'(sBufAddr), 32'(i));
      expectByte($sformatf("data%0d", i), exp, 2'd2, (i == len - 1));
      if (i == 0) checkOutput("miss", 32'(sMiss), 32'(!buf_ready));
      crc = tbCrc(crc, exp);
      rcv = tbCrc(rcv, sData);
    end
    if (nBytes == len) begin
`ifdef FLOPPY_STREAM_CRC_EN
      expCrc = crc;
`else
      expCrc = 16'h0000;
`endif
      applyStimulus(1'b0, 1'b0);
      expectByte("dcrc_hi", expCrc[15:8], 2'd3, 1'b0);
      rcv = tbCrc(rcv, sData);
      applyStimulus(1'b0, 1'b0);
      expectByte("dcrc_lo", expCrc[7:0], 2'd3, 1'b1);
      rcv = tbCrc(rcv, sData);
`ifdef FLOPPY_STREAM_CRC_EN
      checkOutput("data_residue", 32'(rcv), 32'd0);
`endif
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_after_dcrc", 32'(sValid), 32'd0);
    end
  endtask

  task automatic runRow(input vec_t v);
    doStart(v.trk, v.sec, v.sd, v.size, v.len, v.dens);
    doHeader(v.id0, v.id1, v.id2, v.id3, v.dens != 2'd0);
    doData(int'(v.len), v.seed, v.dens != 2'd0, int'(v.len), v.stall);
  endtask

  initial begin
    reset_n = 1'b0; dclk_en = 1'b0; sector_hdr = 1'b0; sector_data = 1'b0;
    track = 8'h00; sector = 5'd0; side = 1'b0; size_code = 2'd0;
    sector_len = 11'd256; density = 2'd0; buf_ready = 1'b1; tbSeed = 8'h00;

    //            trk    side  sec     size  len      dens  seed   stall  id bytes
    vecs[0] = '{8'h03, 1'b0, 5'd1,  2'd1, 11'd256, 2'd0, 8'h00, -1, 8'h03, 8'h00, 8'h01, 8'h01};
    vecs[1] = '{8'h4F, 1'b1, 5'd18, 2'd2, 11'd16,  2'd1, 8'hA5,  7, 8'h4F, 8'h01, 8'h12, 8'h02};
    vecs[2] = '{8'h00, 1'b1, 5'd31, 2'd3, 11'd1,   2'd2, 8'h3C, -1, 8'h00, 8'h01, 8'h1F, 8'h03};
    vecs[3] = '{8'hFF, 1'b0, 5'd0,  2'd0, 11'd3,   2'd0, 8'hFF, -1, 8'hFF, 8'h00, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid",  32'(out_valid), 32'd0);
    checkOutput("rst_data",   32'(out_data), 32'd0);
    checkOutput("rst_kind",   32'(out_kind), 32'd0);
    checkOutput("rst_last",   32'(out_last), 32'd0);
    checkOutput("rst_req",    32'(req), 32'd0);
    checkOutput("rst_rtrack", 32'(req_track), 32'd0);
    checkOutput("rst_rsect",  32'(req_sector), 32'd0);
    checkOutput("rst_bufrd",  32'(buf_rd), 32'd0);
    checkOutput("rst_miss",   32'(miss), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_quiet", 32'(sValid), 32'd0);
    checkOutput("idle_no_rd", 32'(sBufRd), 32'd0);

    for (int v = 0; v < 4; v++) begin
      runRow(vecs[v]);
    end

    // Buffer not ready at the first data byte.
    buf_ready = 1'b0;
    runRow(vecs[0]);
    buf_ready = 1'b1;

    // Header rises at data index 100, then the new data window closes early.
    doStart(8'h03, 5'd1, 1'b0, 2'd1, 11'd256, 2'd0);
    doHeader(8'h03, 8'h00, 8'h01, 8'h01, 1'b0);
    doData(256, 8'h00, 1'b0, 100, -1);
    track = 8'h07; sector = 5'd2;
    applyStimulus(1'b1, 1'b1);
    checkOutput("resync_quiet",  32'(sValid), 32'd0);
    checkOutput("resync_no_rd",  32'(sBufRd), 32'd0);
    checkOutput("resync_req",    32'(sReq), 32'd1);
    checkOutput("resync_rtrack", 32'(req_track), 32'h07);
    checkOutput("resync_rsect",  32'(req_sector), 32'd2);
    doHeader(8'h07, 8'h00, 8'h02, 8'h01, 1'b0);
    doData(256, 8'h00, 1'b0, 2, -1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_quiet", 32'(sValid), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_idle",    32'(sValid), 32'd0);
    checkOutput("abort_idle_rd", 32'(sBufRd), 32'd0);

    // Reset asserted during the tick of data index 50.
    doStart(8'h03, 5'd1, 1'b0, 2'd1, 11'd256, 2'd0);
    doHeader(8'h03, 8'h00, 8'h01, 8'h01, 1'b0);
    doData(256, 8'h00, 1'b0, 50, -1);
    @(posedge clk); #1;
    sector_hdr = 1'b0; sector_data = 1'b1; dclk_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mrst_valid",  32'(out_valid), 32'd0);
    checkOutput("mrst_data",   32'(out_data), 32'd0);
    checkOutput("mrst_kind",   32'(out_kind), 32'd0);
    checkOutput("mrst_bufrd",  32'(buf_rd), 32'd0);
    checkOutput("mrst_addr",   32'(buf_addr), 32'd0);
    checkOutput("mrst_rtrack", 32'(req_track), 32'd0);
    checkOutput("mrst_rsect",  32'(req_sector), 32'd0);
    @(posedge clk); #1;
    dclk_en = 1'b0;
    checkOutput("mrst_no_byte", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("mrst_idle", 32'(sValid), 32'd0);
    runRow(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/floppy_sector_stream.md
Name: floppy_sector_stream

Overview:
- Sits directly downstream of the virtual floppy drive model.
- On each drive byte tick it turns the drive's sector_hdr/sector_data windows into an ordered byte stream for the FDC read path.
- Stream content: ID field (track, side, sector, size code, CRC) followed by sector data fetched from the SD-backed sector buffer, then the data CRC.
- Also issues the sector-buffer fetch request for the sector now under the head.

Parameters:
- SECT_AW, 11, sector buffer address width (sectors up to 1024 bytes)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dclk_en  in  1  drive byte tick, one clk wide
- sector_hdr  in  1  drive header window active
- sector_data  in  1  drive data window active
- track  in  8  track under head
- sector  in  5  sector under head
- side  in  1  head select
- size_code  in  2  ID-field length code (0=128, 1=256, 2=512, 3=1024)
- sector_len  in  11  data bytes per sector
- density  in  2  0=SD, otherwise MFM
- req  out  1  one-clk pulse: fetch req_track/req_sector into buffer
- req_track  out  8  latched track
- req_sector  out  5  latched sector
- buf_ready  in  1  buffer holds the requested sector
- buf_rd  out  1  buffer read strobe
- buf_addr  out  SECT_AW  buffer byte address
- buf_din  in  8  buffer data, valid 1 clk after buf_rd
- out_valid  out  1  one-clk pulse per stream byte
- out_data  out  8  stream byte
- out_kind  out  2  0=ID byte, 1=ID CRC, 2=data byte, 3=data CRC
- out_last  out  1  marks the final byte of a field
- miss  out  1  sticky per sector: buffer was not ready at the first data byte

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC register 0xFFFF.
- States: IDLE, HDR, DATA, DCRC.
- All FSM and counter updates occur only on dclk_en. Output latency is exactly 1 clk after the dclk_en that consumes a byte, for every byte kind.
- IDLE→HDR: on a dclk_en with sector_hdr=1.
  - Latch track/sector into req_track/req_sector.
  - Pulse req in the same clk.
  - Clear miss; set byte index to 0.
- HDR, index 0..5:
  - Emits track, side (0x00/0x01), sector, size_code, CRC[15:8], CRC[7:0].
  - Index 5 sets out_last.
  - After index 5, go to DATA.
- DATA: waits for a dclk_en with sector_data=1, then emits sector_len bytes in order.
  - Per data byte: buf_rd=1 and buf_addr=index in the dclk_en clk; out_data=buf_din on the next clk.
  - If buf_ready=0 on the first data byte, set miss and emit 0x00 for the rest of the sector (no buf_rd).
  - Last data byte (index sector_len-1) sets out_last; then go to DCRC.
- DCRC: emits data CRC hi, then lo, on the next two dclk_en (last on lo), then returns to IDLE. These two bytes occupy the first two gap bytes; the drive gap is always ≥2 bytes.
- CRC: CRC-16-CCITT, poly 0x1021, MSB first, preset 0xFFFF.
  - Before each field the CRC is advanced over the address mark: SD 0xFE (ID) / 0xFB (data); MFM A1,A1,A1 then FE/FB.
  - The CRC covers all payload bytes of the field. A correct field plus its CRC yields residue 0x0000.
- Resync:
  - A rising sector_hdr seen on dclk_en while in DATA or DCRC aborts the current field; FSM enters HDR at index 0 and issues a new req.
  - sector_data falling before index sector_len-1 also aborts to IDLE, emitting no CRC bytes.
- dclk_en stalled (motor off): FSM and counters hold; no outputs.
- Async reset mid-field: immediate return to the reset state; no partial byte emitted.

Optional Feature:
- FLOPPY_STREAM_CRC_EN defined: CRC generator present and CRC bytes emitted as specified.
- Undefined: CRC logic omitted; CRC bytes emitted as 0x00 with unchanged timing and out_kind.

Decomposition:
- Shared package floppy_pkg:
  - state enum
  - out_kind codes
  - address-mark constants 0xA1, 0xFE, 0xFB
  - CRC_POLY 0x1021 and CRC_INIT 0xFFFF
  - ID_LEN 6
- One sub-module, floppy_crc16: byte-wide CCITT update with init, enable and 8-bit data inputs; 16-bit CRC output.

Test Plan:
- SD, track 3, side 0, sector 1, size_code 1, sector_len 256, buffer pattern addr[7:0], buf_ready=1 -> req pulse with req_track=3, req_sector=1; ID bytes 03,00,01,01; 256 data bytes 00..FF; every out_valid exactly 1 clk after its dclk_en.
- CRC check (macro on): pass ID and data fields plus their CRC bytes through a bench CCITT model seeded with the same marks -> residue 0x0000 in both SD and MFM.
- buf_ready=0 at the first data byte -> miss=1, all 256 data bytes 0x00, no buf_rd, CRC bytes still emitted.
- sector_hdr rises mid-DATA at index 100 -> field aborted, new req, ID sequence restarts at index 0.
- dclk_en held low for 1000 clk mid-data, then resumed -> byte index continues with no skip or repeat.
- reset_n asserted at data index 50 -> all outputs 0 the same clk; after release, FSM waits in IDLE for the next sector_hdr.
